// File: rtl/ls_usb_send.sv
// Low-speed USB bit-level transmitter: NRZI coding, bit stuffing, EOP, keep-alive and bus reset.
// Define LS_USB_SEND_KEEPALIVE_EN to send keep-alive EOPs on eof; otherwise eof is ignored.
module ls_usb_send (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_impulse,
  input  logic       eof,
  input  logic [7:0] sbyte,
  input  logic       start_pkt,
  input  logic       last_pkt_byte,
  input  logic       cmd_reset,
  input  logic       cmd_enable,
  output logic       dp,
  output logic       dm,
  output logic       bus_enable,
  output logic       show_next,
  output logic       pkt_end
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_EOP_SE0,
    S_EOP_J,
    S_BUSRESET
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic       last_q, last_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] ones_q, ones_d;
  logic       done_q, done_d;
  logic [1:0] eop_cnt_q, eop_cnt_d;
  logic       keepalive_q, keepalive_d;
  logic       dp_q, dp_d;
  logic       dm_q, dm_d;
  logic       oe_q, oe_d;
  logic       show_next_q, show_next_d;
  logic       pkt_end_q, pkt_end_d;
  logic       eof_req;

`ifdef LS_USB_SEND_KEEPALIVE_EN
  assign eof_req = eof;
`else
  assign eof_req = eof & 1'b0;
`endif

  assign dp         = dp_q;
  assign dm         = dm_q;
  assign bus_enable = oe_q;
  assign show_next  = show_next_q;
  assign pkt_end    = pkt_end_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      last_q      <= 1'b0;
      bit_cnt_q   <= '0;
      ones_q      <= '0;
      done_q      <= 1'b0;
      eop_cnt_q   <= '0;
      keepalive_q <= 1'b0;
      dp_q        <= 1'b0;
      dm_q        <= 1'b1;
      oe_q        <= 1'b0;
      show_next_q <= 1'b0;
      pkt_end_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      last_q      <= last_d;
      bit_cnt_q   <= bit_cnt_d;
      ones_q      <= ones_d;
      done_q      <= done_d;
      eop_cnt_q   <= eop_cnt_d;
      keepalive_q <= keepalive_d;
      dp_q        <= dp_d;
      dm_q        <= dm_d;
      oe_q        <= oe_d;
      show_next_q <= show_next_d;
      pkt_end_q   <= pkt_end_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    last_d      = last_q;
    bit_cnt_d   = bit_cnt_q;
    ones_d      = ones_q;
    done_d      = done_q;
    eop_cnt_d   = eop_cnt_q;
    keepalive_d = keepalive_q;
    dp_d        = dp_q;
    dm_d        = dm_q;
    oe_d        = oe_q;
    show_next_d = 1'b0;
    pkt_end_d   = 1'b0;

    if (cmd_reset) begin
      state_d = S_BUSRESET;
      dp_d    = 1'b0;
      dm_d    = 1'b0;
      oe_d    = 1'b1;
      ones_d  = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          dp_d   = 1'b0;
          dm_d   = 1'b1;
          oe_d   = 1'b0;
          ones_d = '0;
          if (start_pkt && cmd_enable) begin
            state_d     = S_DATA;
            shift_d     = sbyte;
            last_d      = last_pkt_byte;
            bit_cnt_d   = '0;
            done_d      = 1'b0;
            keepalive_d = 1'b0;
          end else if (eof_req && cmd_enable) begin
            // Enter without driving yet; the first SE0 goes out on the next bit slot.
            state_d     = S_EOP_SE0;
            eop_cnt_d   = 2'd0;
            keepalive_d = 1'b1;
          end
        end

        S_DATA: begin
          if (bit_impulse) begin
            oe_d = 1'b1;
            if (ones_q == 3'd6) begin
              dp_d   = dm_q;
              dm_d   = dp_q;
              ones_d = '0;
            end else if (done_q) begin
              // This slot is the first SE0 of the EOP.
              dp_d      = 1'b0;
              dm_d      = 1'b0;
              state_d   = S_EOP_SE0;
              eop_cnt_d = 2'd1;
            end else begin
              if (shift_q[0]) begin
                ones_d = ones_q + 3'd1;
              end else begin
                dp_d   = dm_q;
                dm_d   = dp_q;
                ones_d = '0;
              end
              shift_d   = {1'b0, shift_q[7:1]};
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (last_q) begin
                  done_d = 1'b1;
                end else begin
                  shift_d     = sbyte;
                  last_d      = last_pkt_byte;
                  show_next_d = 1'b1;
                end
              end
            end
          end
        end

        S_EOP_SE0: begin
          if (bit_impulse) begin
            oe_d = 1'b1;
            if (eop_cnt_q == 2'd2) begin
              dp_d    = 1'b0;
              dm_d    = 1'b1;
              state_d = S_EOP_J;
            end else begin
              dp_d      = 1'b0;
              dm_d      = 1'b0;
              eop_cnt_d = eop_cnt_q + 2'd1;
            end
          end
        end

        S_EOP_J: begin
          if (bit_impulse) begin
            oe_d      = 1'b0;
            dp_d      = 1'b0;
            dm_d      = 1'b1;
            state_d   = S_IDLE;
            pkt_end_d = ~keepalive_q;
          end
        end

        S_BUSRESET: begin
          state_d = S_IDLE;
          dp_d    = 1'b0;
          dm_d    = 1'b1;
          oe_d    = 1'b0;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ls_usb_send.sv
// Testbench for ls_usb_send: random and directed packets checked slot-by-slot against an NRZI/stuffing model.
module tb_ls_usb_send;

  localparam logic [2:0] SL_J    = 3'b101;
  localparam logic [2:0] SL_K    = 3'b110;
  localparam logic [2:0] SL_SE0  = 3'b100;
  localparam logic [2:0] SL_IDLE = 3'b001;

  logic       clk = 1'b0;
  logic       reset, bit_impulse, eof, start_pkt, last_pkt_byte, cmd_reset, cmd_enable;
  logic [7:0] sbyte;
  logic       dp, dm, bus_enable, show_next, pkt_end;

  int n_cmp = 0;
  int n_bad = 0;
  int phase = 0;
  int sn_cnt = 0;
  int pe_cnt = 0;

  logic [7:0] pkt[$];
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  ls_usb_send dut (
    .clk          (clk),
    .reset        (reset),
    .bit_impulse  (bit_impulse),
    .eof          (eof),
    .sbyte        (sbyte),
    .start_pkt    (start_pkt),
    .last_pkt_byte(last_pkt_byte),
    .cmd_reset    (cmd_reset),
    .cmd_enable   (cmd_enable),
    .dp           (dp),
    .dm           (dm),
    .bus_enable   (bus_enable),
    .show_next    (show_next),
    .pkt_end      (pkt_end)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: bit_impulse every 8th clock; outputs sampled 1 ns after the edge.
  task automatic cycle(output bit slot);
    bit_impulse = (phase == 7);
    @(posedge clk);
    #1;
    slot      = bit_impulse;
    phase     = (phase + 1) % 8;
    start_pkt = 1'b0;
    eof       = 1'b0;
    if (show_next) sn_cnt++;
    if (pkt_end) pe_cnt++;
  endtask

  // Expected line per bit slot: data bits LSB first, NRZI, stuff after 6 ones, SE0 SE0 J, idle.
  task automatic build_expected();
    bit lvl_j;
    int ones;
    lvl_j = 1'b1;
    ones  = 0;
    exp_q.delete();
    foreach (pkt[i]) begin
      for (int b = 0; b < 8; b++) begin
        if (pkt[i][b] == 1'b0) begin
          lvl_j = ~lvl_j;
          ones  = 0;
        end else begin
          ones++;
        end
        exp_q.push_back(lvl_j ? SL_J : SL_K);
        if (ones == 6) begin
          lvl_j = ~lvl_j;
          ones  = 0;
          exp_q.push_back(lvl_j ? SL_J : SL_K);
        end
      end
    end
    exp_q.push_back(SL_SE0);
    exp_q.push_back(SL_SE0);
    exp_q.push_back(SL_J);
    exp_q.push_back(SL_IDLE);
  endtask

  task automatic present(input int pres);
    if (pres < pkt.size()) begin
      sbyte         = pkt[pres];
      last_pkt_byte = (pres == pkt.size() - 1);
    end else begin
      sbyte         = 8'($urandom);
      last_pkt_byte = 1'($urandom);
    end
  endtask

  task automatic run_packet(input string name, input bit noise);
    int pres, k, budget;
    bit s;
    build_expected();
    sn_cnt = 0;
    pe_cnt = 0;
    sbyte = pkt[0];
    last_pkt_byte = (pkt.size() == 1);
    start_pkt = 1'b1;
    k = 0;
    budget = 0;
    pres = 0;
    while (k < exp_q.size() && budget < 20000) begin
      cycle(s);
      budget++;
      if (budget == 1) pres = 1;
      else if (show_next) pres++;
      present(pres);
      if (s && budget > 1) begin
        check($sformatf("%s slot%0d", name, k), {29'd0, bus_enable, dp, dm}, {29'd0, exp_q[k]});
        if (k == exp_q.size() - 1) check($sformatf("%s pkt_end_at_idle", name), {31'd0, pkt_end}, 32'd1);
        k++;
      end
      if (noise && k + 4 < exp_q.size()) begin
        start_pkt = ($urandom_range(0, 15) == 0);
        eof       = ($urandom_range(0, 15) == 0);
      end
    end
    if (budget >= 20000) check($sformatf("%s timeout", name), 32'd0, 32'd1);
    repeat (16) cycle(s);
    check($sformatf("%s show_next_count", name), sn_cnt, pkt.size() - 1);
    check($sformatf("%s pkt_end_count", name), pe_cnt, 32'd1);
    $display("pkt %s: %0d bytes, %0d slots, show_next=%0d pkt_end=%0d", name, pkt.size(), exp_q.size(), sn_cnt, pe_cnt);
  endtask

  // Runs a stimulus expected to produce exp_q slots without a data packet.
  task automatic run_quiet(input string name, input bit poke_start);
    int k, budget;
    bit s;
    sn_cnt = 0;
    pe_cnt = 0;
    k = 0;
    budget = 0;
    while (k < exp_q.size() && budget < 2000) begin
      cycle(s);
      budget++;
      if (s && budget > 1) begin
        check($sformatf("%s slot%0d", name, k), {29'd0, bus_enable, dp, dm}, {29'd0, exp_q[k]});
        k++;
      end
      if (poke_start && budget == 10) begin
        sbyte = 8'h80;
        last_pkt_byte = 1'b1;
        start_pkt = 1'b1;
      end
    end
    if (budget >= 2000) check($sformatf("%s timeout", name), 32'd0, 32'd1);
    repeat (16) cycle(s);
    check($sformatf("%s show_next_count", name), sn_cnt, 32'd0);
    check($sformatf("%s pkt_end_count", name), pe_cnt, 32'd0);
    $display("quiet %s: %0d slots, show_next=%0d pkt_end=%0d", name, exp_q.size(), sn_cnt, pe_cnt);
  endtask

  // Starts a packet and services the host side for ncyc clocks without checking.
  task automatic run_partial(input int ncyc);
    int pres;
    bit s;
    sn_cnt = 0;
    pe_cnt = 0;
    sbyte = pkt[0];
    last_pkt_byte = (pkt.size() == 1);
    start_pkt = 1'b1;
    pres = 0;
    for (int c = 0; c < ncyc; c++) begin
      cycle(s);
      if (c == 0) pres = 1;
      else if (show_next) pres++;
      present(pres);
    end
  endtask

  initial begin
    bit s;
    logic [7:0] choice;
    int n;
    reset = 1'b1;
    bit_impulse = 1'b0;
    eof = 1'b0;
    sbyte = 8'h00;
    start_pkt = 1'b0;
    last_pkt_byte = 1'b0;
    cmd_reset = 1'b0;
    cmd_enable = 1'b1;

    // Power-on reset held for 500 ns.
    repeat (50) cycle(s);
    check("reset lines", {29'd0, bus_enable, dp, dm}, {29'd0, SL_IDLE});
    check("reset show_next", {31'd0, show_next}, 32'd0);
    check("reset pkt_end", {31'd0, pkt_end}, 32'd0);
    check("reset pulses", sn_cnt + pe_cnt, 32'd0);
    $display("reset: lines=%b%b%b", bus_enable, dp, dm);
    reset = 1'b0;
    repeat (5) cycle(s);

    pkt.delete();
    pkt.push_back(8'h80); pkt.push_back(8'hA5); pkt.push_back(8'h73); pkt.push_back(8'h23);
    run_packet("sync_a5_73_23", 1'b0);

    pkt.delete();
    pkt.push_back(8'h80); pkt.push_back(8'hFF); pkt.push_back(8'hFF);
    run_packet("stuff_ff_ff", 1'b0);
    check("stuff_ff_ff slots", exp_q.size() - 4, 32'd26);

    pkt.delete();
    pkt.push_back(8'h80); pkt.push_back(8'hFC);
    run_packet("stuff_after_last", 1'b0);

    for (int t = 0; t < 6; t++) begin
      pkt.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0: choice = 8'hFF;
          1: choice = 8'hFC;
          2: choice = 8'h7F;
          default: choice = 8'($urandom);
        endcase
        pkt.push_back(choice);
      end
      run_packet($sformatf("rand%0d", t), 1'b1);
      repeat ($urandom_range(1, 20)) cycle(s);
    end

    // Keep-alive request while idle.
    exp_q.delete();
`ifdef LS_USB_SEND_KEEPALIVE_EN
    exp_q.push_back(SL_SE0); exp_q.push_back(SL_SE0); exp_q.push_back(SL_J); exp_q.push_back(SL_IDLE);
    eof = 1'b1;
    run_quiet("keepalive", 1'b1);
`else
    repeat (4) exp_q.push_back(SL_IDLE);
    eof = 1'b1;
    run_quiet("keepalive_off", 1'b0);
`endif

    // Port disabled: start_pkt and eof both blocked.
    cmd_enable = 1'b0;
    exp_q.delete();
    repeat (4) exp_q.push_back(SL_IDLE);
    sbyte = 8'h80;
    last_pkt_byte = 1'b1;
    start_pkt = 1'b1;
    eof = 1'b1;
    run_quiet("disabled", 1'b0);
    cmd_enable = 1'b1;

    // Bus reset mid-packet.
    pkt.delete();
    pkt.push_back(8'h80); pkt.push_back(8'hA5); pkt.push_back(8'h73);
    run_partial(100);
    cmd_reset = 1'b1;
    cycle(s);
    check("busreset entry", {29'd0, bus_enable, dp, dm}, {29'd0, SL_SE0});
    repeat (20) cycle(s);
    check("busreset hold", {29'd0, bus_enable, dp, dm}, {29'd0, SL_SE0});
    cmd_reset = 1'b0;
    cycle(s);
    check("busreset exit", {29'd0, bus_enable, dp, dm}, {29'd0, SL_IDLE});
    repeat (40) cycle(s);
    check("busreset pkt_end_count", pe_cnt, 32'd0);
    check("busreset quiet", {29'd0, bus_enable, dp, dm}, {29'd0, SL_IDLE});
    $display("busreset: aborted packet, pkt_end=%0d", pe_cnt);

    // Asynchronous reset mid-packet, then restart on the first clock after release.
    run_partial(150);
    #2;
    reset = 1'b1;
    #1;
    check("async reset lines", {29'd0, bus_enable, dp, dm}, {29'd0, SL_IDLE});
    check("async reset show_next", {31'd0, show_next}, 32'd0);
    repeat (3) cycle(s);
    check("async reset pkt_end_count", pe_cnt, 32'd0);
    $display("async reset: aborted packet, pkt_end=%0d", pe_cnt);
    reset = 1'b0;
    pkt.delete();
    pkt.push_back(8'h80); pkt.push_back(8'h3C); pkt.push_back(8'hFF);
    run_packet("after_reset", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
